// File: rtl/int_ctrl_pkg.sv
// Shared constants and types for the vectored interrupt controller.
package int_ctrl_pkg;

   localparam logic [1:0] CSR_MASK = 2'd0;
   localparam logic [1:0] CSR_PEND = 2'd1;
   localparam logic [1:0] CSR_INSV = 2'd2;
   localparam logic [1:0] CSR_CTRL = 2'd3;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_REQ  = 1'b1
   } state_e;

   // Index width that stays legal for a single channel.
   function automatic int unsigned idx_w(int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/int_ctrl_if.sv
// CPU-side request/ack handshake and register port of the interrupt controller.
interface int_ctrl_if
   import int_ctrl_pkg::*;
#(
   parameter int unsigned N_IRQ  = 8,
   parameter int unsigned DATA_W = 16,
   parameter int unsigned ADDR_W = 16
);
   localparam int unsigned ID_W = idx_w(N_IRQ);

   logic              int_req;
   logic [ADDR_W-1:0] int_vec;
   logic [ID_W-1:0]   int_id;
   logic              int_ack;
   logic              int_ret;
   logic              csr_we;
   logic [1:0]        csr_addr;
   logic [DATA_W-1:0] csr_wdata;
   logic [DATA_W-1:0] csr_rdata;

   modport master (
      input  int_req, int_vec, int_id, csr_rdata,
      output int_ack, int_ret, csr_we, csr_addr, csr_wdata
   );

   modport slave (
      output int_req, int_vec, int_id, csr_rdata,
      input  int_ack, int_ret, csr_we, csr_addr, csr_wdata
   );

endinterface

// File: rtl/int_prio_enc.sv
// Lowest-set-bit priority encoder: bit 0 wins.
module int_prio_enc
   import int_ctrl_pkg::*;
#(
   parameter int unsigned N = 8
) (
   input  logic [N-1:0]        vec,
   output logic                valid,
   output logic [idx_w(N)-1:0] idx
);
   localparam int unsigned W = idx_w(N);

   always_comb begin
      valid = 1'b0;
      idx   = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (vec[i]) begin
            valid = 1'b1;
            idx   = W'(i);
         end
      end
   end

endmodule

// File: rtl/int_ctrl.sv
// Vectored, prioritised, edge-triggered interrupt controller with a 4-register CSR port.
// Define INT_CTRL_NEST_EN to let higher-priority channels preempt an in-service one.
module int_ctrl
   import int_ctrl_pkg::*;
#(
   parameter int unsigned       N_IRQ      = 8,
   parameter int unsigned       DATA_W     = 16,
   parameter int unsigned       ADDR_W     = 16,
   parameter logic [ADDR_W-1:0] VEC_BASE   = 16'h0010,
   parameter int unsigned       VEC_STRIDE = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_IRQ-1:0] irq,
   int_ctrl_if.slave        bus
);
   localparam int unsigned ID_W = idx_w(N_IRQ);

   logic [N_IRQ-1:0] sync1_q, sync2_q, sync3_q, edge_det;
   logic [N_IRQ-1:0] mask_q, mask_d, pend_q, pend_d, insv_q, insv_d;
   logic             ctrl_q, ctrl_d;
   state_e           state_q, state_d;
   logic [ID_W-1:0]  id_q, id_d;

   logic [N_IRQ-1:0] cand, id_oh, insv_oh, wdata_n;
   logic             cand_valid, insv_valid, eligible, take_ack;
   logic             wr_mask, wr_pend, wr_ctrl;
   logic [ID_W-1:0]  cand_idx, insv_idx;
   logic [DATA_W-1:0] rdata;
   logic             unused_wdata;

   assign unused_wdata = ^bus.csr_wdata;
   assign wdata_n      = bus.csr_wdata[N_IRQ-1:0];
   assign wr_mask      = bus.csr_we && (bus.csr_addr == CSR_MASK);
   assign wr_pend      = bus.csr_we && (bus.csr_addr == CSR_PEND);
   assign wr_ctrl      = bus.csr_we && (bus.csr_addr == CSR_CTRL);

   // sync3 holds the previous synchronised level for rising-edge detection.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
         sync3_q <= '0;
      end else begin
         sync1_q <= irq;
         sync2_q <= sync1_q;
         sync3_q <= sync2_q;
      end
   end

   assign edge_det = sync2_q & ~sync3_q;
   assign cand     = pend_q & mask_q & {N_IRQ{ctrl_q}};
   assign take_ack = (state_q == ST_REQ) && bus.int_ack;
   assign id_oh    = N_IRQ'(1) << id_q;
   assign insv_oh  = N_IRQ'(1) << insv_idx;

   int_prio_enc #(.N(N_IRQ)) u_cand_enc (
      .vec   (cand),
      .valid (cand_valid),
      .idx   (cand_idx)
   );

   int_prio_enc #(.N(N_IRQ)) u_insv_enc (
      .vec   (insv_q),
      .valid (insv_valid),
      .idx   (insv_idx)
   );

`ifdef INT_CTRL_NEST_EN
   assign eligible = !insv_valid || (cand_idx < insv_idx);
`else
   assign eligible = !insv_valid;
`endif

   // New edges win over both ack-clear and W1C; ret clears before ack sets.
   always_comb begin
      mask_d = wr_mask ? wdata_n : mask_q;
      ctrl_d = wr_ctrl ? bus.csr_wdata[0] : ctrl_q;
      pend_d = pend_q;
      if (wr_pend)  pend_d = pend_d & ~wdata_n;
      if (take_ack) pend_d = pend_d & ~id_oh;
      pend_d = pend_d | edge_det;
      insv_d = insv_q;
      if (bus.int_ret && insv_valid) insv_d = insv_d & ~insv_oh;
      if (take_ack)                  insv_d = insv_d | id_oh;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mask_q <= '0;
         pend_q <= '0;
         insv_q <= '0;
         ctrl_q <= 1'b0;
      end else begin
         mask_q <= mask_d;
         pend_q <= pend_d;
         insv_q <= insv_d;
         ctrl_q <= ctrl_d;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         id_q    <= '0;
      end else begin
         state_q <= state_d;
         id_q    <= id_d;
      end
   end

   always_comb begin
      state_d = state_q;
      id_d    = id_q;
      case (state_q)
         ST_IDLE: begin
            if (cand_valid && eligible) begin
               state_d = ST_REQ;
               id_d    = cand_idx;
            end
         end
         ST_REQ: begin
            if (bus.int_ack) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      bus.int_req = 1'b0;
      bus.int_id  = '0;
      bus.int_vec = '0;
      if (state_q == ST_REQ) begin
         bus.int_req = 1'b1;
         bus.int_id  = id_q;
         bus.int_vec = VEC_BASE + ADDR_W'(id_q) * ADDR_W'(VEC_STRIDE);
      end
   end

   always_comb begin
      rdata = '0;
      case (bus.csr_addr)
         CSR_MASK: rdata[N_IRQ-1:0] = mask_q;
         CSR_PEND: rdata[N_IRQ-1:0] = pend_q;
         CSR_INSV: rdata[N_IRQ-1:0] = insv_q;
         CSR_CTRL: rdata[0]         = ctrl_q;
         default:  rdata = '0;
      endcase
   end

   assign bus.csr_rdata = rdata;

endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl: per-cycle vector table plus hand-written corner sequences.
module tb_int_ctrl;
   import int_ctrl_pkg::*;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] irq = 8'h00;
   int         errors = 0;
   int         checks = 0;

   int_ctrl_if #(.N_IRQ(8), .DATA_W(16), .ADDR_W(16)) bus ();

   int_ctrl #(
      .N_IRQ(8), .DATA_W(16), .ADDR_W(16), .VEC_BASE(16'h0010), .VEC_STRIDE(4)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .irq   (irq),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  irq;
      logic        we;
      logic [1:0]  addr;
      logic [15:0] wdata;
      logic        ack;
      logic        ret;
      logic [1:0]  raddr;
      logic        req;
      logic [2:0]  id;
      logic [15:0] vec;
      logic [15:0] rd;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(logic [7:0] i, logic w, logic [1:0] a, logic [15:0] d,
                               logic k, logic r, logic [1:0] ra, logic q, logic [2:0] id,
                               logic [15:0] v, logic [15:0] rd);
      vec_t t;
      t.irq = i; t.we = w; t.addr = a; t.wdata = d; t.ack = k; t.ret = r;
      t.raddr = ra; t.req = q; t.id = id; t.vec = v; t.rd = rd;
      return t;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      bus.csr_we  = 1'b0;
      bus.int_ack = 1'b0;
      bus.int_ret = 1'b0;
   endtask

   task automatic rd(input logic [1:0] a, input logic [15:0] exp, input string nm);
      bus.csr_addr = a;
      #1;
      chk(nm, bus.csr_rdata, exp);
   endtask

   task automatic wr(input logic [1:0] a, input logic [15:0] d);
      bus.csr_we    = 1'b1;
      bus.csr_addr  = a;
      bus.csr_wdata = d;
      step();
   endtask

   task automatic req_chk(input string nm, input logic q, input logic [2:0] id);
      chk({nm, " req"}, bus.int_req, q);
      if (q) begin
         chk({nm, " id"}, bus.int_id, id);
         chk({nm, " vec"}, bus.int_vec, 16'h0010 + 16'(id) * 16'd4);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.int_ack = 1'b0; bus.int_ret = 1'b0; bus.csr_we = 1'b0;
      bus.csr_addr = 2'd0; bus.csr_wdata = '0;

      // basic request on channel 0
      tbl.push_back(mk(8'h00, 1, CSR_MASK, 16'h0001, 0, 0, CSR_MASK, 0, 0, 0, 16'h0001));
      tbl.push_back(mk(8'h00, 1, CSR_CTRL, 16'hFFFF, 0, 0, CSR_CTRL, 0, 0, 0, 16'h0001));
      tbl.push_back(mk(8'h01, 0, CSR_MASK, 16'h0000, 0, 0, CSR_PEND, 0, 0, 0, 16'h0000));
      tbl.push_back(mk(8'h01, 0, CSR_MASK, 16'h0000, 0, 0, CSR_PEND, 0, 0, 0, 16'h0000));
      tbl.push_back(mk(8'h01, 0, CSR_MASK, 16'h0000, 0, 0, CSR_PEND, 0, 0, 0, 16'h0001));
      tbl.push_back(mk(8'h01, 0, CSR_MASK, 16'h0000, 0, 0, CSR_PEND, 1, 0, 16'h0010, 16'h0001));
      tbl.push_back(mk(8'h01, 0, CSR_MASK, 16'h0000, 1, 0, CSR_INSV, 0, 0, 0, 16'h0001));
      tbl.push_back(mk(8'h01, 0, CSR_MASK, 16'h0000, 0, 0, CSR_PEND, 0, 0, 0, 16'h0000));
      tbl.push_back(mk(8'h00, 0, CSR_MASK, 16'h0000, 0, 1, CSR_INSV, 0, 0, 0, 16'h0000));
      // masking on channel 3
      tbl.push_back(mk(8'h08, 1, CSR_MASK, 16'h0000, 0, 0, CSR_MASK, 0, 0, 0, 16'h0000));
      tbl.push_back(mk(8'h08, 0, CSR_MASK, 16'h0000, 0, 0, CSR_PEND, 0, 0, 0, 16'h0000));
      tbl.push_back(mk(8'h08, 0, CSR_MASK, 16'h0000, 0, 0, CSR_PEND, 0, 0, 0, 16'h0008));
      tbl.push_back(mk(8'h08, 0, CSR_MASK, 16'h0000, 0, 0, CSR_PEND, 0, 0, 0, 16'h0008));
      tbl.push_back(mk(8'h08, 1, CSR_MASK, 16'h0008, 0, 0, CSR_MASK, 0, 0, 0, 16'h0008));
      tbl.push_back(mk(8'h08, 0, CSR_MASK, 16'h0000, 0, 0, CSR_PEND, 1, 3, 16'h001C, 16'h0008));
      tbl.push_back(mk(8'h08, 0, CSR_MASK, 16'h0000, 1, 0, CSR_INSV, 0, 0, 0, 16'h0008));
      tbl.push_back(mk(8'h08, 0, CSR_MASK, 16'h0000, 0, 1, CSR_INSV, 0, 0, 0, 16'h0000));
      // W1C of a pending bit while idle
      tbl.push_back(mk(8'h00, 1, CSR_CTRL, 16'h0000, 0, 0, CSR_CTRL, 0, 0, 0, 16'h0000));
      tbl.push_back(mk(8'h08, 0, CSR_MASK, 16'h0000, 0, 0, CSR_PEND, 0, 0, 0, 16'h0000));
      tbl.push_back(mk(8'h08, 0, CSR_MASK, 16'h0000, 0, 0, CSR_PEND, 0, 0, 0, 16'h0000));
      tbl.push_back(mk(8'h08, 0, CSR_MASK, 16'h0000, 0, 0, CSR_PEND, 0, 0, 0, 16'h0008));
      tbl.push_back(mk(8'h08, 1, CSR_PEND, 16'h0008, 0, 0, CSR_PEND, 0, 0, 0, 16'h0000));
      tbl.push_back(mk(8'h08, 1, CSR_CTRL, 16'h0001, 0, 0, CSR_PEND, 0, 0, 0, 16'h0000));
      tbl.push_back(mk(8'h08, 0, CSR_MASK, 16'h0000, 0, 0, CSR_PEND, 0, 0, 0, 16'h0000));
      // unimplemented bits and read-only register
      tbl.push_back(mk(8'h08, 1, CSR_MASK, 16'hFFFF, 0, 0, CSR_MASK, 0, 0, 0, 16'h00FF));
      tbl.push_back(mk(8'h08, 1, CSR_INSV, 16'hFFFF, 0, 0, CSR_INSV, 0, 0, 0, 16'h0000));
      // priority 2 over 5, request held while channel 0 arrives and mask changes
      tbl.push_back(mk(8'h2C, 0, CSR_MASK, 16'h0000, 0, 0, CSR_PEND, 0, 0, 0, 16'h0000));
      tbl.push_back(mk(8'h2C, 0, CSR_MASK, 16'h0000, 0, 0, CSR_PEND, 0, 0, 0, 16'h0000));
      tbl.push_back(mk(8'h2C, 0, CSR_MASK, 16'h0000, 0, 0, CSR_PEND, 0, 0, 0, 16'h0024));
      tbl.push_back(mk(8'h2C, 0, CSR_MASK, 16'h0000, 0, 0, CSR_PEND, 1, 2, 16'h0018, 16'h0024));
      tbl.push_back(mk(8'h2D, 0, CSR_MASK, 16'h0000, 0, 0, CSR_PEND, 1, 2, 16'h0018, 16'h0024));
      tbl.push_back(mk(8'h2D, 0, CSR_MASK, 16'h0000, 0, 0, CSR_PEND, 1, 2, 16'h0018, 16'h0024));
      tbl.push_back(mk(8'h2D, 0, CSR_MASK, 16'h0000, 0, 0, CSR_PEND, 1, 2, 16'h0018, 16'h0025));
      tbl.push_back(mk(8'h2D, 1, CSR_MASK, 16'h00FA, 0, 0, CSR_MASK, 1, 2, 16'h0018, 16'h00FA));
      tbl.push_back(mk(8'h2D, 0, CSR_MASK, 16'h0000, 1, 0, CSR_INSV, 0, 0, 0, 16'h0004));
      tbl.push_back(mk(8'h2D, 0, CSR_MASK, 16'h0000, 0, 0, CSR_PEND, 0, 0, 0, 16'h0021));
      tbl.push_back(mk(8'h2D, 0, CSR_MASK, 16'h0000, 0, 1, CSR_INSV, 0, 0, 0, 16'h0000));
      tbl.push_back(mk(8'h2D, 0, CSR_MASK, 16'h0000, 0, 0, CSR_PEND, 1, 5, 16'h0024, 16'h0021));
      tbl.push_back(mk(8'h2D, 0, CSR_MASK, 16'h0000, 1, 0, CSR_INSV, 0, 0, 0, 16'h0020));
      tbl.push_back(mk(8'h2D, 0, CSR_MASK, 16'h0000, 0, 1, CSR_INSV, 0, 0, 0, 16'h0000));

      // reset state
      repeat (2) @(posedge clk);
      #1;
      req_chk("rst", 1'b0, 3'd0);
      chk("rst id", bus.int_id, 3'd0);
      chk("rst vec", bus.int_vec, 16'h0000);
      rd(CSR_MASK, 16'h0000, "rst mask");
      rd(CSR_PEND, 16'h0000, "rst pend");
      rd(CSR_INSV, 16'h0000, "rst insv");
      rd(CSR_CTRL, 16'h0000, "rst ctrl");
      @(negedge clk);
      reset = 1'b1;
      step();

      foreach (tbl[i]) begin
         irq           = tbl[i].irq;
         bus.csr_we    = tbl[i].we;
         bus.csr_addr  = tbl[i].addr;
         bus.csr_wdata = tbl[i].wdata;
         bus.int_ack   = tbl[i].ack;
         bus.int_ret   = tbl[i].ret;
         step();
         bus.csr_addr = tbl[i].raddr;
         #1;
         chk($sformatf("v%0d req", i), bus.int_req, tbl[i].req);
         if (tbl[i].req) begin
            chk($sformatf("v%0d id", i), bus.int_id, tbl[i].id);
            chk($sformatf("v%0d vec", i), bus.int_vec, tbl[i].vec);
         end
         chk($sformatf("v%0d rdata", i), bus.csr_rdata, tbl[i].rd);
      end

      // nesting: channel 3 in service, channel 1 arrives
      irq = 8'h00;
      wr(CSR_PEND, 16'h00FF);
      wr(CSR_MASK, 16'h00FF);
      repeat (3) step();
      req_chk("nest quiet", 1'b0, 3'd0);
      rd(CSR_PEND, 16'h0000, "nest quiet pend");
      irq = 8'h08;
      repeat (4) step();
      req_chk("nest ch3", 1'b1, 3'd3);
      bus.int_ack = 1'b1;
      step();
      rd(CSR_INSV, 16'h0008, "nest insv3");
      irq = 8'h0A;
      repeat (3) step();
      rd(CSR_PEND, 16'h0002, "nest pend1");
      step();
`ifdef INT_CTRL_NEST_EN
      req_chk("nest preempt", 1'b1, 3'd1);
      bus.int_ack = 1'b1;
      step();
      rd(CSR_INSV, 16'h000A, "nest insv31");
      bus.int_ret = 1'b1;
      step();
      rd(CSR_INSV, 16'h0008, "nest ret1");
      bus.int_ret = 1'b1;
      step();
      rd(CSR_INSV, 16'h0000, "nest ret3");
`else
      req_chk("nonest blocked", 1'b0, 3'd0);
      step();
      req_chk("nonest blocked2", 1'b0, 3'd0);
      bus.int_ret = 1'b1;
      step();
      rd(CSR_INSV, 16'h0000, "nonest ret3");
      req_chk("nonest idle", 1'b0, 3'd0);
      step();
      req_chk("nonest ch1", 1'b1, 3'd1);
      bus.int_ack = 1'b1;
      step();
      rd(CSR_INSV, 16'h0002, "nonest insv1");
      bus.int_ret = 1'b1;
      step();
      rd(CSR_INSV, 16'h0000, "nonest ret1");
`endif

      // ret with nothing in service
      bus.int_ret = 1'b1;
      step();
      rd(CSR_INSV, 16'h0000, "ret empty insv");
      rd(CSR_PEND, 16'h0000, "ret empty pend");

      // edge on channel 4 in its own ack cycle
      irq = 8'h1A;
      repeat (4) step();
      req_chk("ch4 req", 1'b1, 3'd4);
      irq = 8'h0A;
      repeat (3) step();
      req_chk("ch4 held", 1'b1, 3'd4);
      irq = 8'h1A;
      repeat (2) step();
      bus.int_ack = 1'b1;
      step();
      req_chk("ch4 acked", 1'b0, 3'd0);
      rd(CSR_PEND, 16'h0010, "ch4 pend kept");
      rd(CSR_INSV, 16'h0010, "ch4 insv");
      step();
      req_chk("ch4 not eligible", 1'b0, 3'd0);
      bus.int_ret = 1'b1;
      step();
      step();
      req_chk("ch4 again", 1'b1, 3'd4);
      bus.int_ack = 1'b1;
      step();
      bus.int_ret = 1'b1;
      step();
      rd(CSR_INSV, 16'h0000, "ch4 done insv");

      // edge on channel 6 in the same cycle as its W1C
      wr(CSR_CTRL, 16'h0000);
      irq = 8'h5A;
      repeat (2) step();
      wr(CSR_PEND, 16'h0040);
      rd(CSR_PEND, 16'h0040, "w1c edge kept");
      wr(CSR_PEND, 16'h0040);
      rd(CSR_PEND, 16'h0000, "w1c clears");

      // asynchronous reset while requesting
      wr(CSR_CTRL, 16'h0001);
      irq = 8'hDA;
      repeat (4) step();
      req_chk("ch7 req", 1'b1, 3'd7);
      #2;
      reset = 1'b0;
      #1;
      chk("arst req", bus.int_req, 1'b0);
      chk("arst id", bus.int_id, 3'd0);
      chk("arst vec", bus.int_vec, 16'h0000);
      rd(CSR_MASK, 16'h0000, "arst mask");
      rd(CSR_PEND, 16'h0000, "arst pend");
      rd(CSR_INSV, 16'h0000, "arst insv");
      rd(CSR_CTRL, 16'h0000, "arst ctrl");
      irq = 8'h00;
      @(posedge clk);
      #2;
      reset = 1'b1;
      repeat (5) step();
      req_chk("post rst", 1'b0, 3'd0);
      wr(CSR_MASK, 16'h00FF);
      wr(CSR_CTRL, 16'h0001);
      repeat (4) step();
      req_chk("post rst armed", 1'b0, 3'd0);
      rd(CSR_PEND, 16'h0000, "post rst pend");
      irq = 8'h80;
      repeat (4) step();
      req_chk("post rst ch7", 1'b1, 3'd7);
      bus.int_ack = 1'b1;
      step();
      req_chk("post rst ack", 1'b0, 3'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/int_ctrl.md
# int_ctrl

Parametrised vectored interrupt controller sitting between the external interrupt lines and the CPU core. It replaces the fixed 8-line interrupt input with N prioritised, maskable, edge-triggered channels. It presents one request at a time, with a vector address, to the control unit's call-interrupt path, and tracks in-service state across return-from-interrupt. Software configures and inspects it through a small register port on the data bus.

## Interface
- N_IRQ, 8: number of interrupt channels, 1..DATA_W; channel 0 has highest priority.
- DATA_W, 16: register-port data width.
- ADDR_W, 16: vector address width.
- VEC_BASE, 16'h0010: vector of channel 0.
- VEC_STRIDE, 4: address distance between consecutive channel vectors.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- irq  in  N_IRQ  raw external interrupt lines, asynchronous.
- int_req  out  1  interrupt request to the CPU.
- int_vec  out  ADDR_W  vector address; valid while int_req=1.
- int_id  out  $clog2(N_IRQ)  channel being requested; valid while int_req=1.
- int_ack  in  1  CPU takes the interrupt (call-interrupt cycle).
- int_ret  in  1  CPU executes return-from-interrupt.
- csr_we  in  1  register write strobe.
- csr_addr  in  2  register select.
- csr_wdata  in  DATA_W  write data.
- csr_rdata  out  DATA_W  combinational read data of the selected register.

## Operation
- Each irq bit passes through a 2-FF synchroniser followed by a rising-edge detector. A detected edge sets pending[i].
- Registers:
  - 0 = mask; 1 = channel enabled.
  - 1 = pending; read, write-1-to-clear.
  - 2 = in_service; read-only.
  - 3 = ctrl; bit0 is the global enable, other bits read 0.
- Bits at or above N_IRQ read 0 and ignore writes.
- Candidate = lowest index i with pending[i] & mask[i], when ctrl.bit0=1.
- FSM states:
  - IDLE: when a candidate exists and is eligible (see Configuration), latch id, go to REQ.
  - REQ: int_req=1; int_id and int_vec are held stable even if a higher-priority channel becomes pending. On int_ack, clear pending[id], set in_service[id], go to IDLE.
  - REQ is left only by int_ack or reset. Masking or clearing the latched channel while in REQ does not withdraw the request.
- int_vec = VEC_BASE + id*VEC_STRIDE, truncated to ADDR_W.
- int_ret clears the lowest-index set bit of in_service. With in_service=0 it has no effect.
- Simultaneous events:
  - Edge on channel i in the same cycle as ack of i: pending[i] stays 1.
  - Edge in the same cycle as W1C of the same bit: pending stays 1.
  - int_ret and int_ack in the same cycle: the ret clear is applied to the old in_service, then the ack set.
- Reset (asynchronous, any state):
  - int_req=0, int_vec=0, int_id=0.
  - pending, mask, in_service, ctrl=0, synchronisers=0.
  - FSM=IDLE.

## Timing
- irq rising edge to pending set: 3 clk edges (2 sync, 1 edge-detect/set).
- Pending set to int_req=1: 1 cycle, provided FSM is IDLE and the candidate is eligible.
- int_req drops the cycle after int_ack is sampled high. The next request can assert 1 cycle after that, since IDLE always takes one cycle.
- A CSR write takes effect on the clock edge. The candidate uses the new values from the following cycle.

## Configuration
- INT_CTRL_NEST_EN defined: a candidate is eligible if in_service=0, or if its index is lower than the lowest set in_service bit. Higher-priority channels preempt; nesting depth is bounded by N_IRQ.
- INT_CTRL_NEST_EN undefined: a candidate is eligible only if in_service=0. in_service holds at most one bit, and int_ret clears it.

## Structure
- Package int_ctrl_pkg:
  - CSR address constants: CSR_MASK, CSR_PEND, CSR_INSV, CSR_CTRL.
  - FSM state encoding: ST_IDLE, ST_REQ.
- Sub-module int_prio_enc (parameter N): lowest-set-bit encoder, outputs a valid flag and an index. Two instances: one over the candidate vector, one over in_service (used for eligibility and for int_ret).

## Test plan
- Basic request: reset, mask=8'h01, ctrl=1, pulse irq[0] → int_req=1 on the 4th edge, int_vec=16'h0010; ack → in_service=8'h01, int_req=0 next cycle.
- Priority: irq[5] and irq[2] rise together, mask=8'hFF → first request int_id=2, vector 16'h0018; after ack, ret, then channel 5 with vector 16'h0024.
- Nesting with INT_CTRL_NEST_EN: in_service=8'h08, irq[1] rises → int_req with id=1. Same stimulus without the macro → no request until int_ret.
- Masking: irq[3] pending with mask=0 → no int_req, pending reads 8'h08. Write mask=8'h08 → int_req 1 cycle later. W1C 8'h08 in IDLE → pending=0, no request.
- Boundary events: irq[4] edge in the ack cycle of channel 4 → pending[4] stays 1. Int_ret with in_service=0 → no change.
- Asynchronous reset asserted while in REQ → int_req=0 and all registers 0 immediately. No request after release until a new edge arrives.
